load_store_unit: RTL and testbench

- Multi-cycle data-memory access stage directly downstream of the single-cycle RV32I execute datapath.
- Takes the ALU-computed effective address, rs2 store data, funct3 and destination register, and performs RV32I LB/LH/LW/LBU/LHU/SB/SH/SW over a request/grant/response data bus.
- Handles byte-lane steering, byte enables, load sign/zero extension, misalignment detection and bus timeout.
- Returns load data tagged with rd for register write-back.

---
 rtl/load_store_unit.sv | 185 ++++++++++++++++++
 tb/tb_load_store_unit.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// RV32I load/store stage: one memory op in flight over a req/gnt/rvalid bus,
// with lane steering, load extension, alignment faults and bus timeout.
module load_store_unit #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        is_store_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic [4:0]  rd_addr_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_be_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic        resp_valid_o,
  output logic [31:0] resp_rdata_o,
  output logic [4:0]  resp_rd_o,
  output logic        resp_we_o,
  output logic        misaligned_o,
  output logic        bus_err_o
);

  localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

  state_t            r_state, w_next;
  logic              r_is_store, r_mis, r_berr;
  logic [2:0]        r_funct3;
  logic [31:0]       r_addr, r_wdata, r_rdata;
  logic [4:0]        r_rd;
  logic [CNT_W-1:0]  r_cnt;
  logic              w_fault, w_busy, w_done, w_tout;

  function automatic logic is_fault(input logic st, input logic [2:0] f3,
                                    input logic [1:0] off);
    logic bad;
    case (f3)
      3'b000:  bad = 1'b0;
      3'b001:  bad = off[0];
      3'b010:  bad = (off != 2'b00);
      3'b100:  bad = st;
      3'b101:  bad = st | off[0];
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  function automatic logic [31:0] steer_wdata(input logic [2:0] f3, input logic [31:0] w);
    case (f3[1:0])
      2'b00:   return {4{w[7:0]}};
      2'b01:   return {2{w[15:0]}};
      default: return w;
    endcase
  endfunction

  function automatic logic [3:0] steer_be(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b00:   return 4'b0001 << off;
      2'b01:   return 4'b0011 << off;
      default: return 4'b1111;
    endcase
  endfunction

  // Shift the addressed lane down to bit 0, then sign- or zero-extend by funct3.
  function automatic logic [31:0] extend_load(input logic [2:0] f3, input logic [1:0] off,
                                              input logic [31:0] word);
    logic        [31:0] sh;
    logic signed [7:0]  b_s;
    logic signed [15:0] h_s;
    sh  = word >> {off, 3'b000};
    b_s = sh[7:0];
    h_s = sh[15:0];
    case (f3)
      3'b000:  return 32'(b_s);
      3'b100:  return {24'd0, sh[7:0]};
      3'b001:  return 32'(h_s);
      3'b101:  return {16'd0, sh[15:0]};
      default: return sh;
    endcase
  endfunction

  assign w_fault = is_fault(is_store_i, funct3_i, addr_i[1:0]);
  assign w_busy  = (r_state == S_REQ) || (r_state == S_WAIT);
  assign w_done  = ((r_state == S_REQ) && mem_gnt_i && mem_rvalid_i) ||
                   ((r_state == S_WAIT) && mem_rvalid_i);
  assign w_tout  = w_busy && !w_done && (r_cnt == CNT_LAST);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (req_valid_i) w_next = w_fault ? S_RESP : S_REQ;
      S_REQ: begin
        if (w_done || w_tout) w_next = S_RESP;
        else if (mem_gnt_i)   w_next = S_WAIT;
      end
      S_WAIT: if (w_done || w_tout) w_next = S_RESP;
      default: w_next = S_IDLE;
    endcase
  end

  // Captured op fields, timeout counter and response registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_is_store <= 1'b0;
      r_funct3   <= 3'd0;
      r_addr     <= 32'd0;
      r_wdata    <= 32'd0;
      r_rd       <= 5'd0;
      r_rdata    <= 32'd0;
      r_mis      <= 1'b0;
      r_berr     <= 1'b0;
      r_cnt      <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (req_valid_i) begin
          r_is_store <= is_store_i;
          r_funct3   <= funct3_i;
          r_addr     <= addr_i;
          r_wdata    <= wdata_i;
          r_rd       <= rd_addr_i;
          r_rdata    <= 32'd0;
          r_mis      <= w_fault;
          r_berr     <= 1'b0;
          r_cnt      <= '0;
        end
        S_REQ, S_WAIT: begin
          if (w_done) begin
            if (!r_is_store) r_rdata <= extend_load(r_funct3, r_addr[1:0], mem_rdata_i);
          end else if (w_tout) begin
            r_berr <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    req_ready_o  = (r_state == S_IDLE);
    mem_req_o    = 1'b0;
    mem_we_o     = 1'b0;
    mem_addr_o   = 32'd0;
    mem_wdata_o  = 32'd0;
    mem_be_o     = 4'd0;
    resp_valid_o = 1'b0;
    resp_rdata_o = 32'd0;
    resp_rd_o    = 5'd0;
    resp_we_o    = 1'b0;
    misaligned_o = 1'b0;
    bus_err_o    = 1'b0;
    if (r_state == S_REQ) begin
      mem_req_o   = 1'b1;
      mem_we_o    = r_is_store;
      mem_addr_o  = {r_addr[31:2], 2'b00};
      mem_wdata_o = r_is_store ? steer_wdata(r_funct3, r_wdata) : 32'd0;
      mem_be_o    = r_is_store ? steer_be(r_funct3, r_addr[1:0]) : 4'b1111;
    end
    if (r_state == S_RESP) begin
      resp_valid_o = 1'b1;
      resp_rdata_o = r_rdata;
      resp_rd_o    = r_rd;
      resp_we_o    = !r_is_store && !r_mis && !r_berr;
      misaligned_o = r_mis;
      bus_err_o    = r_berr;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed vector table, randomized ops against a
// byte-level reference model, and a reset-during-WAIT sequence.
module tb_load_store_unit;

  localparam int TO = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid_i = 1'b0, is_store_i = 1'b0;
  logic [2:0]  funct3_i = 3'd0;
  logic [31:0] addr_i = 32'd0, wdata_i = 32'd0, mem_rdata_i = 32'd0;
  logic [4:0]  rd_addr_i = 5'd0;
  logic        mem_gnt_i = 1'b0, mem_rvalid_i = 1'b0;
  logic        req_ready_o, mem_req_o, mem_we_o, resp_valid_o, resp_we_o;
  logic        misaligned_o, bus_err_o;
  logic [31:0] mem_addr_o, mem_wdata_o, resp_rdata_o;
  logic [3:0]  mem_be_o;
  logic [4:0]  resp_rd_o;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .clock(clock), .reset(reset),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .is_store_i(is_store_i), .funct3_i(funct3_i), .addr_i(addr_i),
    .wdata_i(wdata_i), .rd_addr_i(rd_addr_i),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o),
    .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .resp_valid_o(resp_valid_o), .resp_rdata_o(resp_rdata_o), .resp_rd_o(resp_rd_o),
    .resp_we_o(resp_we_o), .misaligned_o(misaligned_o), .bus_err_o(bus_err_o)
  );

  typedef struct {
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [4:0]  rd;
    int          gd;      // REQ cycles before gnt (0 = first REQ cycle)
    int          rl;      // cycles from gnt to rvalid (0 = same cycle)
    logic        e_mis;
    logic        e_berr;
    logic [31:0] e_rdata;
    logic [3:0]  e_be;
    logic [31:0] e_wdata;
    int          e_lat;   // cycle index after accept at which resp_valid_o is seen
    int          e_reqc;  // number of cycles mem_req_o is high
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic st, input logic [2:0] f3, input logic [31:0] a,
                              input logic [31:0] wd, input logic [31:0] rdat, input logic [4:0] rd,
                              input int gd, input int rl, input logic mis, input logic berr,
                              input logic [31:0] erd, input logic [3:0] ebe,
                              input logic [31:0] ewd, input int lat, input int reqc);
    vec_t v;
    v.st = st; v.f3 = f3; v.addr = a; v.wdata = wd; v.rdata = rdat; v.rd = rd;
    v.gd = gd; v.rl = rl; v.e_mis = mis; v.e_berr = berr; v.e_rdata = erd;
    v.e_be = ebe; v.e_wdata = ewd; v.e_lat = lat; v.e_reqc = reqc;
    return v;
  endfunction

  // Reference model: access size in bytes, lanes taken byte by byte from the word.
  function automatic vec_t model(input vec_t v);
    vec_t        r;
    int          n, off, gcyc, done;
    logic        legal;
    logic [3:0]  m;
    logic [31:0] val;
    r = v;
    n = (v.f3[1:0] == 2'd0) ? 1 : (v.f3[1:0] == 2'd1) ? 2 : 4;
    off = int'(v.addr % 4);
    legal = v.st ? (v.f3 <= 3'd2)
                 : (v.f3 == 3'd0 || v.f3 == 3'd1 || v.f3 == 3'd2 || v.f3 == 3'd4 || v.f3 == 3'd5);
    r.e_mis = !legal || ((off % n) != 0);
    r.e_berr = 1'b0; r.e_rdata = 32'd0; r.e_be = 4'hF; r.e_wdata = 32'd0;
    if (r.e_mis) begin
      r.e_lat = 1; r.e_reqc = 0;
      return r;
    end
    gcyc = 1 + v.gd;
    done = gcyc + v.rl;
    if (done <= TO) r.e_lat = done + 1;
    else begin r.e_berr = 1'b1; r.e_lat = TO + 1; end
    r.e_reqc = (gcyc < TO) ? gcyc : TO;
    if (v.st) begin
      m = 4'((1 << n) - 1);
      r.e_be = m << off;
      for (int i = 0; i < 4; i++) r.e_wdata[8*i +: 8] = v.wdata[8*(i % n) +: 8];
    end else if (!r.e_berr) begin
      val = 32'd0;
      for (int i = 0; i < n; i++) val[8*i +: 8] = v.rdata[8*(off + i) +: 8];
      if (!v.f3[2] && n < 4 && val[8*n - 1]) val = val | ~((32'h1 << (8*n)) - 32'h1);
      r.e_rdata = val;
    end
    return r;
  endfunction

  task automatic apply(input vec_t v, input string nm);
    int          cyc, reqc, gcyc, lat;
    logic        granted, saw, o_mis, o_berr, o_we, b_we;
    logic [31:0] o_rdata, b_addr, b_wd;
    logic [4:0]  o_rd;
    logic [3:0]  b_be;
    @(negedge clock);
    chk({nm, " ready"}, 32'(req_ready_o), 32'd1);
    req_valid_i = 1'b1; is_store_i = v.st; funct3_i = v.f3; addr_i = v.addr;
    wdata_i = v.wdata; rd_addr_i = v.rd;
    @(posedge clock);
    saw = 1'b0; granted = 1'b0; reqc = 0; gcyc = 0; lat = 0;
    o_mis = 1'b0; o_berr = 1'b0; o_we = 1'b0; o_rdata = 32'd0; o_rd = 5'd0;
    b_we = 1'b0; b_addr = 32'd0; b_wd = 32'd0; b_be = 4'd0;
    cyc = 1;
    while (cyc <= 12 && !saw) begin
      @(negedge clock);
      req_valid_i = 1'b0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = $urandom;
      if (resp_valid_o) begin
        saw = 1'b1; lat = cyc;
        o_mis = misaligned_o; o_berr = bus_err_o; o_we = resp_we_o;
        o_rdata = resp_rdata_o; o_rd = resp_rd_o;
      end else begin
        if (mem_req_o) begin
          if (reqc == 0) begin
            b_we = mem_we_o; b_addr = mem_addr_o; b_wd = mem_wdata_o; b_be = mem_be_o;
          end
          reqc++;
          if (!granted && cyc == 1 + v.gd) begin
            mem_gnt_i = 1'b1; granted = 1'b1; gcyc = cyc;
          end
        end
        if (granted && cyc == gcyc + v.rl) begin
          mem_rvalid_i = 1'b1; mem_rdata_i = v.rdata;
        end
        @(posedge clock);
        cyc++;
      end
    end
    chk({nm, " resp_seen"}, 32'(saw), 32'd1);
    chk({nm, " latency"}, 32'(lat), 32'(v.e_lat));
    chk({nm, " misaligned"}, 32'(o_mis), 32'(v.e_mis));
    chk({nm, " bus_err"}, 32'(o_berr), 32'(v.e_berr));
    chk({nm, " rdata"}, o_rdata, v.e_rdata);
    chk({nm, " rd"}, 32'(o_rd), 32'(v.rd));
    chk({nm, " resp_we"}, 32'(o_we), 32'(!v.st && !v.e_mis && !v.e_berr));
    chk({nm, " req_cycles"}, 32'(reqc), 32'(v.e_reqc));
    if (reqc > 0) begin
      chk({nm, " mem_addr"}, b_addr, {v.addr[31:2], 2'b00});
      chk({nm, " mem_we"}, 32'(b_we), 32'(v.st));
      chk({nm, " mem_be"}, 32'(b_be), 32'(v.e_be));
      if (v.st) chk({nm, " mem_wdata"}, b_wd, v.e_wdata);
    end
    @(negedge clock);
    chk({nm, " resp_one_cycle"}, {30'd0, resp_valid_o, req_ready_o}, 32'd1);
  endtask

  initial begin
    vec_t tbl[14];
    vec_t v;
    int   pulses;

    tbl[0]  = mk(0, 3'd2, 32'h100, 32'h0, 32'hDEADBEEF, 5'd5, 0, 2, 0, 0, 32'hDEADBEEF, 4'hF, 32'h0, 4, 1);
    tbl[1]  = mk(0, 3'd0, 32'h103, 32'h0, 32'h80FFFF7F, 5'd6, 0, 0, 0, 0, 32'hFFFFFF80, 4'hF, 32'h0, 2, 1);
    tbl[2]  = mk(0, 3'd4, 32'h103, 32'h0, 32'h80FFFF7F, 5'd7, 1, 0, 0, 0, 32'h00000080, 4'hF, 32'h0, 3, 2);
    tbl[3]  = mk(0, 3'd1, 32'h102, 32'h0, 32'h80010000, 5'd8, 0, 1, 0, 0, 32'hFFFF8001, 4'hF, 32'h0, 3, 1);
    tbl[4]  = mk(1, 3'd0, 32'h201, 32'hA5, 32'hFFFFFFFF, 5'd9, 0, 0, 0, 0, 32'h0, 4'b0010, 32'hA5A5A5A5, 2, 1);
    tbl[5]  = mk(1, 3'd1, 32'h202, 32'h1234, 32'hFFFFFFFF, 5'd10, 2, 1, 0, 0, 32'h0, 4'b1100, 32'h12341234, 5, 3);
    tbl[6]  = mk(0, 3'd2, 32'h102, 32'h0, 32'h12345678, 5'd11, 0, 0, 1, 0, 32'h0, 4'hF, 32'h0, 1, 0);
    tbl[7]  = mk(0, 3'd1, 32'h101, 32'h0, 32'h12345678, 5'd12, 0, 0, 1, 0, 32'h0, 4'hF, 32'h0, 1, 0);
    tbl[8]  = mk(0, 3'd5, 32'h102, 32'h0, 32'h80010000, 5'd13, 0, 0, 0, 0, 32'h00008001, 4'hF, 32'h0, 2, 1);
    tbl[9]  = mk(1, 3'd2, 32'h300, 32'h11223344, 32'hFFFFFFFF, 5'd14, 1, 1, 0, 0, 32'h0, 4'hF, 32'h11223344, 4, 2);
    tbl[10] = mk(0, 3'd3, 32'h0, 32'h0, 32'h12345678, 5'd15, 0, 0, 1, 0, 32'h0, 4'hF, 32'h0, 1, 0);
    tbl[11] = mk(1, 3'd4, 32'h0, 32'hCAFE, 32'h12345678, 5'd16, 0, 0, 1, 0, 32'h0, 4'hF, 32'h0, 1, 0);
    tbl[12] = mk(0, 3'd2, 32'h104, 32'h0, 32'h12345678, 5'd17, 99, 0, 0, 1, 32'h0, 4'hF, 32'h0, 5, 4);
    tbl[13] = mk(0, 3'd2, 32'h108, 32'h0, 32'h00000001, 5'd18, 0, 3, 0, 0, 32'h00000001, 4'hF, 32'h0, 5, 1);

    repeat (2) @(negedge clock);
    chk("reset ready", 32'(req_ready_o), 32'd1);
    chk("reset outputs", {mem_req_o, mem_we_o, mem_be_o, resp_valid_o, resp_we_o,
                          misaligned_o, bus_err_o, resp_rd_o}, 32'd0);
    chk("reset data", mem_addr_o | mem_wdata_o | resp_rdata_o, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 14; i++) apply(tbl[i], $sformatf("vec%0d", i));

    for (int i = 0; i < 40; i++) begin
      v.st = 1'($urandom_range(0, 1));
      v.f3 = 3'($urandom_range(0, 7));
      v.addr = $urandom;
      v.wdata = $urandom;
      v.rdata = $urandom;
      v.rd = 5'($urandom_range(0, 31));
      v.gd = $urandom_range(0, 3);
      v.rl = $urandom_range(0, 3);
      apply(model(v), $sformatf("rnd%0d", i));
    end

    // Reset while waiting for rvalid; a late rvalid must not produce a response.
    @(negedge clock);
    req_valid_i = 1'b1; is_store_i = 1'b0; funct3_i = 3'd2; addr_i = 32'h400; rd_addr_i = 5'd3;
    @(posedge clock);
    @(negedge clock);
    req_valid_i = 1'b0; mem_gnt_i = 1'b1;
    @(posedge clock);
    @(negedge clock);
    mem_gnt_i = 1'b0;
    chk("wait_state req low", 32'(mem_req_o), 32'd0);
    reset = 1'b1;
    #1;
    chk("async reset ready", 32'(req_ready_o), 32'd1);
    @(negedge clock);
    reset = 1'b0;
    pulses = 0;
    @(negedge clock);
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'h55AA55AA;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      mem_rvalid_i = 1'b0;
      if (resp_valid_o) pulses++;
    end
    chk("late rvalid ignored", 32'(pulses), 32'd0);
    chk("ready after reset", 32'(req_ready_o), 32'd1);
    apply(mk(0, 3'd2, 32'h400, 32'h0, 32'h0BADF00D, 5'd3, 0, 1, 0, 0, 32'h0BADF00D,
             4'hF, 32'h0, 3, 1), "post_reset_lw");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
